// File: rtl/ift_trace_capture.sv
// ift_trace_capture: samples an observed {Q, Q_t} pair while armed and queues
// timestamped change records in a small FIFO behind a valid/ready port.
// Sticky flags record dropped captures and the first tainted record.
module ift_trace_capture #(
  parameter int unsigned DATA_W  = 2,
  parameter int unsigned TAINT_W = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TS_W    = 16
) (
  input  logic                              CLK,
  input  logic                              ARST_N,
  input  logic                              CLR,
  input  logic                              CAP_EN,
  input  logic [DATA_W-1:0]                 Q_IN,
  input  logic [TAINT_W-1:0]                Q_T_IN,
  output logic                              REC_VALID,
  input  logic                              REC_READY,
  output logic [TS_W+TAINT_W+DATA_W-1:0]    REC_DATA,
  output logic [$clog2(DEPTH+1)-1:0]        COUNT,
  output logic                              OVERFLOW,
  output logic                              TAINT_SEEN,
  output logic [TS_W-1:0]                   FIRST_TAINT_TS
);

  localparam int unsigned SMP_W = TAINT_W + DATA_W;
  localparam int unsigned REC_W = TS_W + SMP_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    WATCH = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                capture;
  logic                push;
  logic                pop;
  logic                full;
  logic [SMP_W-1:0]    sample;
  logic [SMP_W-1:0]    last;
  logic [TS_W-1:0]     ts;
  logic [PTR_W-1:0]    wptr;
  logic [PTR_W-1:0]    rptr;
  logic [CNT_W-1:0]    count;
  logic [REC_W-1:0]    mem [DEPTH];

  assign sample    = {Q_T_IN, Q_IN};
  assign full      = (count == FULL_CNT);
  assign REC_VALID = (count != '0);
  assign pop       = REC_VALID && REC_READY;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push      = capture && (!full || pop);
  assign COUNT     = count;
  // Head is gated so nothing stale leaks out while the FIFO is empty.
  assign REC_DATA  = REC_VALID ? mem[rptr] : '0;

  // State register.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and capture decision; CLR overrides arming and capture.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (CAP_EN) state_nxt = PRIME;
      end
      PRIME: begin
        if (CAP_EN) begin
          capture   = 1'b1;
          state_nxt = WATCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      WATCH: begin
        if (!CAP_EN) state_nxt = IDLE;
        else         capture   = (sample != last);
      end
      default: state_nxt = IDLE;
    endcase
    if (CLR) begin
      state_nxt = IDLE;
      capture   = 1'b0;
    end
  end

  // Free-running timestamp, cleared by CLR.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N)  ts <= '0;
    else if (CLR) ts <= '0;
    else          ts <= ts + 1'b1;
  end

  // Last-sample register follows every capture, including dropped ones.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N)      last <= '0;
    else if (capture) last <= sample;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (CLR) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= {ts, sample};
  end

  // Sticky overflow and first-taint status.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      OVERFLOW       <= 1'b0;
      TAINT_SEEN     <= 1'b0;
      FIRST_TAINT_TS <= '0;
    end else if (CLR) begin
      OVERFLOW       <= 1'b0;
      TAINT_SEEN     <= 1'b0;
      FIRST_TAINT_TS <= '0;
    end else begin
      if (capture && !push) OVERFLOW <= 1'b1;
      if (push && (Q_T_IN != '0) && !TAINT_SEEN) begin
        TAINT_SEEN     <= 1'b1;
        FIRST_TAINT_TS <= ts;
      end
    end
  end

endmodule

// File: tb/tb_ift_trace_capture.sv
// Bench for ift_trace_capture: directed scenarios with literal expectations
// followed by random stimulus, both checked every cycle against a queue model.
// A second instance with a 4-bit timestamp shares the stimulus.
module tb_ift_trace_capture;

  localparam int unsigned DW   = 2;
  localparam int unsigned TW   = 32;
  localparam int unsigned DEP  = 4;
  localparam int unsigned TSW  = 16;
  localparam int unsigned RW   = TSW + TW + DW;
  localparam int unsigned RW4  = 4 + TW + DW;

  logic          clk;
  logic          arst_n;
  logic          clr;
  logic          cap_en;
  logic [DW-1:0] q_in;
  logic [TW-1:0] qt_in;
  logic          ready;

  logic          rv;
  logic [RW-1:0] rd;
  logic [2:0]    cnt;
  logic          ovf;
  logic          tseen;
  logic [TSW-1:0] fts;

  logic           rv4;
  logic [RW4-1:0] rd4;
  logic [2:0]     cnt4;
  logic           ovf4;
  logic           tseen4;
  logic [3:0]     fts4;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Reference model state.
  logic [TSW-1:0]    m_ts;
  int                m_streak;
  logic [TW+DW-1:0]  m_last;
  logic [RW-1:0]     m_q[$];
  logic              m_ovf;
  logic              m_taint;
  logic [TSW-1:0]    m_first;

  ift_trace_capture #(
    .DATA_W(DW), .TAINT_W(TW), .DEPTH(DEP), .TS_W(TSW)
  ) u_dut (
    .CLK(clk), .ARST_N(arst_n), .CLR(clr), .CAP_EN(cap_en),
    .Q_IN(q_in), .Q_T_IN(qt_in), .REC_VALID(rv), .REC_READY(ready),
    .REC_DATA(rd), .COUNT(cnt), .OVERFLOW(ovf), .TAINT_SEEN(tseen),
    .FIRST_TAINT_TS(fts)
  );

  ift_trace_capture #(
    .DATA_W(DW), .TAINT_W(TW), .DEPTH(DEP), .TS_W(4)
  ) u_dut4 (
    .CLK(clk), .ARST_N(arst_n), .CLR(clr), .CAP_EN(cap_en),
    .Q_IN(q_in), .Q_T_IN(qt_in), .REC_VALID(rv4), .REC_READY(ready),
    .REC_DATA(rd4), .COUNT(cnt4), .OVERFLOW(ovf4), .TAINT_SEEN(tseen4),
    .FIRST_TAINT_TS(fts4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts     = '0;
    m_streak = 0;
    m_last   = '0;
    m_q.delete();
    m_ovf    = 1'b0;
    m_taint  = 1'b0;
    m_first  = '0;
  endtask

  // One clock edge of the model. m_streak counts consecutive armed cycles
  // since the last disarm/clear: 0 = not armed, 1 = first armed cycle
  // (captures unconditionally), 2+ = captures on change only.
  task automatic model_update();
    bit cap;
    bit pop;
    if (!arst_n) begin
      model_reset();
    end else if (clr) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_taint  = 1'b0;
      m_first  = '0;
      m_ts     = '0;
      m_streak = 0;
    end else begin
      pop = (m_q.size() > 0) && ready;
      cap = cap_en && ((m_streak == 1) ||
                       (m_streak >= 2 && {qt_in, q_in} != m_last));
      if (cap_en) m_streak = (m_streak < 2) ? m_streak + 1 : 2;
      else        m_streak = 0;
      if (pop) void'(m_q.pop_front());
      if (cap) begin
        m_last = {qt_in, q_in};
        if (m_q.size() < DEP) begin
          m_q.push_back({m_ts, qt_in, q_in});
          if (qt_in != '0 && !m_taint) begin
            m_taint = 1'b1;
            m_first = m_ts;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_ts = m_ts + 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", 64'(rv), 64'(m_q.size() != 0));
      chk("count", 64'(cnt), 64'(m_q.size()));
      if (m_q.size() != 0) chk("data", 64'(rd), 64'(m_q[0]));
      chk("overflow", 64'(ovf), 64'(m_ovf));
      chk("taint_seen", 64'(tseen), 64'(m_taint));
      chk("first_ts", 64'(fts), 64'(m_first));
      chk("valid4", 64'(rv4), 64'(m_q.size() != 0));
      chk("count4", 64'(cnt4), 64'(m_q.size()));
      if (m_q.size() != 0) chk("data4", 64'(rd4), 64'(m_q[0][RW4-1:0]));
      chk("overflow4", 64'(ovf4), 64'(m_ovf));
      chk("first_ts4", 64'(fts4), 64'(m_first[3:0]));
    end
  end

  task automatic set_pair(input int i);
    q_in  = DW'(i);
    qt_in = 32'h100 + 32'(i);
  endtask

  initial begin
    arst_n = 1'b0;
    clr    = 1'b0;
    cap_en = 1'b0;
    q_in   = '0;
    qt_in  = '0;
    ready  = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", 64'(rv), 64'd0);
    chk("reset_count", 64'(cnt), 64'd0);
    chk("reset_data", 64'(rd), 64'd0);
    arst_n = 1'b1;
    model_reset();
    chk_on = 1'b1;

    // First capture lands at ts=5 with constant inputs.
    repeat (4) tick();
    cap_en = 1'b1;
    q_in   = 2'b01;
    qt_in  = 32'h0;
    tick();
    tick();
    chk("t1_count", 64'(cnt), 64'd1);
    chk("t1_head", 64'(rd), 64'({16'd5, 32'h0, 2'b01}));
    chk("t1_taint", 64'(tseen), 64'd0);
    repeat (4) tick();
    chk("t1_single", 64'(cnt), 64'd1);

    // Taint appears at ts=10; a later change keeps the first timestamp.
    qt_in = 32'h3;
    tick();
    chk("t2_count", 64'(cnt), 64'd2);
    chk("t2_taint", 64'(tseen), 64'd1);
    chk("t2_first", 64'(fts), 64'd10);
    tick();
    qt_in = 32'h7;
    tick();
    chk("t2_first_kept", 64'(fts), 64'd10);
    chk("t2_head", 64'(rd), 64'({16'd5, 32'h0, 2'b01}));

    // Drain, then overflow with six changes on consecutive cycles.
    ready = 1'b1;
    repeat (3) tick();
    chk("t3_empty", 64'(rv), 64'd0);
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_pair(i);
      tick();
    end
    chk("t3_count", 64'(cnt), 64'd4);
    chk("t3_ovf", 64'(ovf), 64'd1);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_order", 64'(rd), 64'({16'(16 + k), 32'(32'h100 + k), 2'(k)}));
      tick();
    end
    chk("t3_drained_valid", 64'(rv), 64'd0);
    chk("t3_drained_count", 64'(cnt), 64'd0);

    // CLR with a partly full FIFO and both sticky flags set.
    ready = 1'b0;
    for (int i = 6; i < 9; i++) begin
      set_pair(i);
      tick();
    end
    chk("t6_pre_count", 64'(cnt), 64'd3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_count", 64'(cnt), 64'd0);
    chk("t6_ovf", 64'(ovf), 64'd0);
    chk("t6_taint", 64'(tseen), 64'd0);
    chk("t6_first", 64'(fts), 64'd0);
    tick();
    chk("t6_idle", 64'(cnt), 64'd0);
    tick();
    chk("t6_prime_head", 64'(rd), 64'({16'd1, 32'h108, 2'b00}));
    chk("t6_prime_count", 64'(cnt), 64'd1);

    // Full FIFO with simultaneous pop and push.
    for (int i = 9; i < 12; i++) begin
      set_pair(i);
      tick();
    end
    chk("t4_full", 64'(cnt), 64'd4);
    ready = 1'b1;
    set_pair(12);
    tick();
    chk("t4_count", 64'(cnt), 64'd4);
    chk("t4_ovf", 64'(ovf), 64'd0);
    chk("t4_head", 64'(rd), 64'({16'd2, 32'h109, 2'b01}));

    // 4-bit timestamp wrap: captures at ts 15 and 0.
    repeat (4) tick();
    ready = 1'b0;
    repeat (5) tick();
    set_pair(13);
    tick();
    set_pair(14);
    tick();
    chk("t5_count4", 64'(cnt4), 64'd2);
    chk("t5_head_f", 64'(rd4), 64'({4'hF, 32'h10D, 2'b01}));
    ready = 1'b1;
    tick();
    chk("t5_head_0", 64'(rd4), 64'({4'h0, 32'h10E, 2'b10}));

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      cap_en = ($urandom_range(0, 19) != 0);
      clr    = ($urandom_range(0, 99) == 0);
      ready  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        q_in  = 2'($urandom);
        qt_in = ($urandom_range(0, 1) != 0) ? 32'h0 : (32'h1 << $urandom_range(0, 31));
      end
      tick();
    end

    // Asynchronous reset while records are waiting to drain.
    clr    = 1'b0;
    cap_en = 1'b1;
    ready  = 1'b0;
    for (int i = 20; i < 24; i++) begin
      set_pair(i);
      tick();
    end
    chk("pre_reset_valid", 64'(rv), 64'd1);
    ready  = 1'b1;
    arst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 64'(rv), 64'd0);
    chk("arst_count", 64'(cnt), 64'd0);
    chk("arst_data", 64'(rd), 64'd0);
    chk("arst_valid4", 64'(rv4), 64'd0);
    #1;
    repeat (2) tick();
    arst_n = 1'b1;
    repeat (4) tick();

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ift_trace_capture.md
Name: ift_trace_capture

Overview:
- Response-side counterpart to the stimulus drivers of the IFT flip-flop benches.
- Samples a DUT output and its taint vector (Q, Q_t) every clock while armed.
- Stores change events as timestamped records in a small FIFO and hands them out over a valid/ready port.
- Keeps sticky taint and overflow status, so taint propagation through sdff/dff variants is checked in hardware, not by post-processing the VCD.

Parameters:
- DATA_W, 2, width of the observed data output Q.
- TAINT_W, 32, width of the taint vector Q_t.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TS_W, 16, timestamp counter width.

Ports:
- CLK  in  1  clock, all state on rising edge.
- ARST_N  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous clear of FIFO, flags, timestamp and FSM.
- CAP_EN  in  1  arm capture.
- Q_IN  in  DATA_W  observed data.
- Q_T_IN  in  TAINT_W  observed taint.
- REC_VALID  out  1  FIFO head valid.
- REC_READY  in  1  consumer accepts head.
- REC_DATA  out  TS_W+TAINT_W+DATA_W  record {ts, taint, data}, MSB first.
- COUNT  out  clog2(DEPTH+1)  FIFO occupancy.
- OVERFLOW  out  1  sticky: a capture was dropped.
- TAINT_SEEN  out  1  sticky: a captured record had non-zero taint.
- FIRST_TAINT_TS  out  TS_W  timestamp of the first tainted record.

Behaviour:
- Reset (ARST_N=0, async):
  - All outputs 0; FIFO empty; FSM IDLE; timestamp 0; last-sample register 0.
- Timestamp:
  - Increments by 1 every cycle after reset, independent of CAP_EN.
  - Wraps 2^TS_W-1 -> 0 silently.
  - CLR sets it to 0 in that cycle.
- FSM:
  - IDLE: no capture. CAP_EN=1 -> PRIME.
  - PRIME: unconditional capture of the current {Q_IN, Q_T_IN}, then -> WATCH.
  - WATCH: capture only when {Q_IN, Q_T_IN} differs from the last captured pair. CAP_EN=0 -> IDLE with no capture that cycle.
  - CAP_EN dropping in PRIME also -> IDLE without capture.
- Capture (push):
  - Writes {ts_current, Q_T_IN, Q_IN} and updates the last-sample register.
  - Record is visible on REC_DATA/REC_VALID the cycle after the sampling edge (1-cycle latency when FIFO was empty).
- Pop:
  - Occurs when REC_VALID & REC_READY at an edge.
  - REC_DATA always shows the head; it is stable while REC_VALID=1 and REC_READY=0.
- Full FIFO:
  - Push with pop in the same cycle: both happen, COUNT unchanged.
  - Push without pop: record dropped, OVERFLOW set; last-sample register still updates, so the dropped value is not re-captured.
- Empty FIFO:
  - REC_VALID=0; REC_READY ignored; COUNT never underflows.
  - Push with REC_READY=1 on an empty FIFO: no bypass, record is pushed and popped on a later cycle.
- Taint flags:
  - TAINT_SEEN and FIRST_TAINT_TS update only on accepted pushes, never on dropped records.
  - On the first push with Q_T_IN != 0, TAINT_SEEN=1 and FIRST_TAINT_TS latches that record's ts; later pushes do not change it.
- CLR (sync, highest priority over push/pop/arm):
  - Empties FIFO, clears OVERFLOW/TAINT_SEEN/FIRST_TAINT_TS/timestamp, FSM -> IDLE.
  - If CAP_EN=1, the FSM re-enters PRIME the next cycle.
- Reset mid-stream: asserting ARST_N=0 discards all records immediately, with no partial outputs.
- Pointer arithmetic: log2(DEPTH)-bit read/write pointers, wrap modulo DEPTH; COUNT is tracked separately.

Test Plan:
- Reset 3 cycles, CAP_EN=1 at ts=5, Q=2'b01, Q_t=0 held constant, REC_READY=0:
  - exactly one record {16'd5, 32'h0, 2'b01}; COUNT=1; TAINT_SEEN=0.
- Q_t changes 0 -> 32'h0000_0003 at ts=10, Q unchanged:
  - second record {16'd10, 32'h3, 2'b01}; TAINT_SEEN=1; FIRST_TAINT_TS=10.
  - a further change at ts=12 leaves FIRST_TAINT_TS=10.
- REC_READY=0, six distinct Q values on consecutive cycles:
  - COUNT saturates at 4, OVERFLOW=1, FIFO holds the first four records in order.
  - then REC_READY=1 drains exactly 4 records, REC_VALID drops, COUNT=0.
- FIFO full, REC_READY=1 and new Q change on the same edge:
  - head popped and new record pushed; COUNT stays 4; OVERFLOW stays 0.
- TS_W=4, capture at ts=15 then ts=0:
  - records carry ts 4'hF then 4'h0, both present and in order.
- CLR pulse with COUNT=3, OVERFLOW=1, TAINT_SEEN=1, CAP_EN=1:
  - next cycle all cleared, ts=0; following cycle PRIME captures current Q with ts=1.
  - separately, ARST_N low mid-drain forces REC_VALID=0 asynchronously.
